// File: rtl/loader_pkg.sv
// loader_pkg: shared states and framing constants for the boot-time code loader.
package loader_pkg;
  typedef enum logic [3:0] {IDLE, CNT_LO, CNT_HI, B0, B1, B2, CSUM, DONE, ERROR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int WORD_BYTES = 3;
endpackage

// File: rtl/code_loader_if.sv
// code_loader_if: byte receiver input, code memory write port and core control.
interface code_loader_if #(parameter int ADDR_SIZE = 18, parameter int WORD_SIZE = 18);
  logic rx_valid;
  logic [7:0] rx_data;
  logic mem_write_enable;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic cpu_reset;
  logic done;
  logic error;
  modport master (input rx_valid, rx_data, output mem_write_enable, mem_addr, mem_data, cpu_reset, done, error);
  modport slave (output rx_valid, rx_data, input mem_write_enable, mem_addr, mem_data, cpu_reset, done, error);
endinterface

// File: rtl/code_loader.sv
// code_loader: assembles framed bytes into 18-bit words, writes code memory, releases the core on a verified image.
module code_loader import loader_pkg::*; #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MEM_SIZE = 1024,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic clock,
  input logic reset,
  code_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [7:0] lo, lo_n, b0, b0_n, b1, b1_n, csum, csum_n;
  logic [15:0] words, words_n;
  logic [TW-1:0] tmr, tmr_n;
  logic we_n, cpu_reset_n, done_n, error_n, fail;
  logic [ADDR_SIZE-1:0] addr_n;
  logic [WORD_SIZE-1:0] data_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      lo <= '0;
      b0 <= '0;
      b1 <= '0;
      csum <= '0;
      words <= '0;
      tmr <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_addr <= ADDR_SIZE'(BASE_ADDR);
      bus.mem_data <= '0;
      bus.cpu_reset <= 1'b1;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= state_n;
      lo <= lo_n;
      b0 <= b0_n;
      b1 <= b1_n;
      csum <= csum_n;
      words <= words_n;
      tmr <= tmr_n;
      bus.mem_write_enable <= we_n;
      bus.mem_addr <= addr_n;
      bus.mem_data <= data_n;
      bus.cpu_reset <= cpu_reset_n;
      bus.done <= done_n;
      bus.error <= error_n;
    end
  end
  always_comb begin
    state_n = state;
    lo_n = lo;
    b0_n = b0;
    b1_n = b1;
    csum_n = csum;
    words_n = words;
    tmr_n = '0;
    we_n = 1'b0;
    addr_n = bus.mem_write_enable ? bus.mem_addr + 1'b1 : bus.mem_addr;
    data_n = bus.mem_data;
    cpu_reset_n = bus.cpu_reset;
    done_n = bus.done;
    error_n = bus.error;
    fail = 1'b0;
    if (state inside {IDLE, DONE, ERROR}) begin
      if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
        state_n = CNT_LO;
        csum_n = '0;
        error_n = 1'b0;
        cpu_reset_n = 1'b1;
        done_n = 1'b0;
      end
    end else if (!bus.rx_valid) begin
      tmr_n = tmr + 1'b1;
      fail = tmr == TW'(TIMEOUT_CYCLES - 1);
    end else begin
      csum_n = state == CSUM ? csum : csum + bus.rx_data;
      unique case (state)
        CNT_LO: begin
          lo_n = bus.rx_data;
          state_n = CNT_HI;
        end
        CNT_HI: begin
          words_n = {bus.rx_data, lo};
          addr_n = ADDR_SIZE'(BASE_ADDR);
          fail = int'({bus.rx_data, lo}) > MEM_SIZE;
          state_n = words_n == '0 ? CSUM : B0;
        end
        B0: begin
          b0_n = bus.rx_data;
          state_n = B1;
        end
        B1: begin
          b1_n = bus.rx_data;
          state_n = B2;
        end
        B2: begin
          fail = |bus.rx_data[7:2];
          we_n = !fail;
          data_n = fail ? bus.mem_data : WORD_SIZE'({bus.rx_data[1:0], b1, b0});
          words_n = words - 1'b1;
          state_n = words == 16'd1 ? CSUM : B0;
        end
        CSUM: begin
          fail = bus.rx_data != csum;
          state_n = DONE;
          done_n = 1'b1;
          cpu_reset_n = 1'b0;
        end
        default: ;
      endcase
    end
    if (fail) begin
      state_n = ERROR;
      error_n = 1'b1;
      done_n = 1'b0;
      cpu_reset_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: directed frames against hand-computed writes and status flags.
module tb_code_loader;
  import loader_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int vecs = 0;
  int errs = 0;
  int nw = 0;
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  logic [7:0] q [$];
  code_loader_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus ();
  code_loader #(.TIMEOUT_CYCLES(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(negedge clock)
    if (bus.mem_write_enable) begin
      if (nw < 8) begin
        wa[nw] = 32'(bus.mem_addr);
        wd[nw] = 32'(bus.mem_data);
      end
      nw++;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_q();
    foreach (q[i]) send(q[i]);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    nw = 0;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    do_reset();
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 1);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_error", 32'(bus.error), 0);
    chk("rst_we", 32'(bus.mem_write_enable), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_data", 32'(bus.mem_data), 0);
    q = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h03, 8'h01, 8'h00, 8'h00, 8'h04};
    send_q();
    chk("nom_writes", 32'(nw), 2);
    chk("nom_a0", wa[0], 32'h0);
    chk("nom_d0", wd[0], 32'h3FFFF);
    chk("nom_a1", wa[1], 32'h1);
    chk("nom_d1", wd[1], 32'h00001);
    chk("nom_done", 32'(bus.done), 1);
    chk("nom_cpu_reset", 32'(bus.cpu_reset), 0);
    chk("nom_error", 32'(bus.error), 0);
    chk("nom_addr", 32'(bus.mem_addr), 2);
    nw = 0;
    q[9] = 8'h05;
    send_q();
    chk("bad_csum_writes", 32'(nw), 2);
    chk("bad_csum_error", 32'(bus.error), 1);
    chk("bad_csum_cpu_reset", 32'(bus.cpu_reset), 1);
    chk("bad_csum_done", 32'(bus.done), 0);
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    chk("recover_done", 32'(bus.done), 1);
    chk("recover_error", 32'(bus.error), 0);
    chk("recover_writes", 32'(nw), 2);
    nw = 0;
    q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    send_q();
    chk("bad_b2_error", 32'(bus.error), 1);
    chk("bad_b2_writes", 32'(nw), 0);
    q = '{8'hA5, 8'h01, 8'h04};
    send_q();
    chk("big_count_error", 32'(bus.error), 1);
    chk("big_count_state", 32'(dut.state), 32'(ERROR));
    chk("big_count_writes", 32'(nw), 0);
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    chk("empty_done", 32'(bus.done), 1);
    chk("empty_cpu_reset", 32'(bus.cpu_reset), 0);
    chk("empty_writes", 32'(nw), 0);
    send(8'hA5);
    chk("reload_done", 32'(bus.done), 0);
    chk("reload_cpu_reset", 32'(bus.cpu_reset), 1);
    do_reset();
    q = '{8'hA5, 8'h02};
    send_q();
    repeat (15) @(negedge clock);
    chk("tmo_15_error", 32'(bus.error), 0);
    @(negedge clock);
    chk("tmo_16_error", 32'(bus.error), 1);
    chk("tmo_cpu_reset", 32'(bus.cpu_reset), 1);
    do_reset();
    q = '{8'hA5, 8'h02};
    send_q();
    repeat (14) @(negedge clock);
    send(8'h00);
    chk("no_tmo_error", 32'(bus.error), 0);
    chk("no_tmo_state", 32'(dut.state), 32'(B0));
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'hFF};
    send_q();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_cpu_reset", 32'(bus.cpu_reset), 1);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_error", 32'(bus.error), 0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 0);
    chk("mid_rst_we", 32'(bus.mem_write_enable), 0);
    reset = 1'b0;
    send(8'h00);
    chk("ignored_state", 32'(dut.state), 32'(IDLE));
    chk("ignored_writes", 32'(nw), 0);
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    chk("post_rst_done", 32'(bus.done), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
- Boot-time program loader upstream of the 18-bit processor core.
- Receives a framed byte stream from a byte-wide receiver (UART RX or similar) and assembles 18-bit code words.
- Writes the words into code memory through that memory's write port.
- Holds the processor in reset until a complete, checksum-verified image has been written.

Parameters:
- ADDR_SIZE, 18, code memory address width.
- WORD_SIZE, 18, code word width; fixed at 18 by the 3-byte word framing.
- MEM_SIZE, 1024, code memory depth in words; upper bound on the image word count.
- BASE_ADDR, 0, address of the first written word.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  8  received byte
- mem_write_enable  out  1  code memory write strobe
- mem_addr  out  ADDR_SIZE  code memory write address
- mem_data  out  WORD_SIZE  code memory write data
- cpu_reset  out  1  reset for the processor core; high while no valid image is loaded
- done  out  1  image loaded and verified
- error  out  1  last frame aborted

Behaviour:
- Reset (clock: clock; reset: reset, synchronous, active-high): state IDLE, cpu_reset=1, done=0, error=0, mem_write_enable=0, mem_addr=BASE_ADDR, mem_data=0, checksum=0, timeout counter=0. Reset mid-frame aborts the frame; words already written stay in memory.
- Outputs are registered. A byte is accepted only in a cycle with rx_valid=1.
- Frame format:
  - sync 0xA5.
  - count_lo, count_hi: word count N, little-endian 16 bits.
  - N x (b0, b1, b2): word = {b2[1:0], b1, b0}.
  - csum: 8-bit sum of all bytes after sync, modulo 256.
- Frame states:
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5: clear checksum and error, set cpu_reset=1, set done=0, go to CNT_LO.
  - CNT_LO: store the low count byte. Go to CNT_HI.
  - CNT_HI: if N > MEM_SIZE, go to ERROR. If N=0, go to CSUM. Otherwise go to B0, with word counter=N and mem_addr=BASE_ADDR.
  - B0, B1: latch the byte. Go to the next byte state.
  - B2: if b2[7:2] is not 0, go to ERROR. Otherwise, on the next clock: mem_write_enable=1 for exactly one cycle, with mem_data={b2[1:0],b1,b0} at the current mem_addr. mem_addr increments after the write. Decrement the word counter; go to CSUM when it reaches 0, else go to B0.
  - CSUM: on a match, go to DONE. On a mismatch, go to ERROR.
  - DONE: done=1 and cpu_reset=0, both effective the clock after csum is accepted. A later 0xA5 starts a reload (as in IDLE).
  - ERROR: error=1 and cpu_reset=1, both effective the clock after the failing byte. A later 0xA5 restarts loading; all other bytes are ignored.
- Checksum: 8-bit accumulator. It adds every accepted byte from count_lo onward, including b2 bytes with bad upper bits before the abort.
- Timeout: a counter clears on every accepted byte and counts in CNT_LO..CSUM only. When it reaches TIMEOUT_CYCLES, go to ERROR. It never fires in IDLE, DONE or ERROR.
- Simultaneous events:
  - reset has priority over rx_valid.
  - In the cycle a byte is accepted, the byte wins over a timeout expiry.
- mem_write_enable is never asserted outside B2 completion. At most one write per 3 accepted bytes.

Decomposition:
- loader_pkg holds:
  - state enum: IDLE, CNT_LO, CNT_HI, B0, B1, B2, CSUM, DONE, ERROR.
  - SYNC_BYTE=8'hA5.
  - WORD_BYTES=3.
- No sub-module; the timeout counter, checksum and word assembly are inline.

Test Plan:
- Nominal two-word image:
  - Stimulus: A5 02 00 FF FF 03 01 00 00 04.
  - Required: writes addr0=0x3FFFF, then addr1=0x00001; one mem_write_enable pulse each.
  - Required: done=1 and cpu_reset=0 one clock after the csum byte; error=0.
- Bad checksum:
  - Stimulus: same frame with csum 05.
  - Required: both words are still written; error=1, cpu_reset=1, done=0.
  - Then A5 00 00 00 gives done=1, error=0.
- Framing errors:
  - b2=0x04 in word 0: error=1 and no write for that word.
  - Count 0x0401 (1025 > MEM_SIZE): error right after count_hi, with zero writes.
- Empty image and reload:
  - Stimulus: A5 00 00 00.
  - Required: done=1, no writes.
  - Then a fresh A5 asserts cpu_reset=1 and drops done=0 on the next clock.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; send A5 02, then idle for 16 clocks.
  - Required: error=1.
  - Also: idle 15 clocks and then send a byte; no error.
- Reset mid-frame:
  - Stimulus: assert reset after A5 01 00 FF.
  - Required: state IDLE, cpu_reset=1, done=0, error=0, mem_addr=BASE_ADDR, no write pulse.
  - Then a following 00 byte is ignored.
